game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Top-level game sequencer. Produces the 2-bit `state` bus consumed by the clock divider and the rest of the game logic.
- Detects one-second ticks from the divider's `oneHz_CLK` output and runs a BCD countdown of game time.
- Interprets debounced start/pause and reset button pulses.
- Owns the RESET/PAUSE/GAME/OVER sequencing, so the divider and display are cleared, frozen and released consistently.

Parameters:
- GAME_SECONDS, 60, initial countdown value in seconds; legal range 1..99.
- RESET_CYCLES, 4, number of clk cycles `state` is held at RESET after any reset event; legal range 1..7.
- RST_CNT_BITS, 3, width of the reset-hold counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_pause  input  1  one-cycle debounced pulse: start/pause toggle
- btn_reset  input  1  one-cycle debounced pulse: game reset request
- one_hz  input  1  `oneHz_CLK` level from the divider; each rising edge is one second
- state  output  2  0=GAME, 1=PAUSE, 2=RESET, 3=OVER; drives the divider state input
- time_tens  output  4  BCD tens digit of remaining seconds
- time_ones  output  4  BCD ones digit of remaining seconds
- time_up  output  1  high while state==OVER
- running  output  1  high while state==GAME

Interface rules:
- Single clock domain, `clk`.
- Reset `rst` is synchronous and active-high.

Behaviour:
- Reset values (rst high, or btn_reset pulse):
  - state=RESET(2); reset-hold counter=0.
  - time = BCD(GAME_SECONDS), e.g. tens=6, ones=0.
  - time_up=0, running=0; one_hz_q=0.
- Tick detection:
  - one_hz_q samples one_hz every cycle, except under rst, where it is cleared.
  - tick = one_hz & ~one_hz_q, combinational.
  - Ticks are only acted on in GAME.
- FSM transitions (registered; outputs are Moore, decoded from the state register):
  - RESET: counter increments each cycle. When counter == RESET_CYCLES-1, go to PAUSE next cycle.
  - PAUSE: btn_pause -> GAME. Ticks are ignored and time is frozen.
  - GAME:
    - btn_pause -> PAUSE.
    - tick: decrement time by 1 in BCD. Ones 0 -> 9 with tens-1; no binary intermediate.
    - tick with time==01 -> time=00 and state=OVER, same edge.
  - OVER: time holds at 00. btn_pause is ignored. Only btn_reset/rst leave OVER.
- btn_reset in any state, including mid-RESET:
  - Restarts the RESET sequence: counter=0, time reloaded.
  - Takes priority over btn_pause and tick in the same cycle.
- Simultaneous tick and btn_pause in GAME:
  - The decrement is applied and state goes to PAUSE.
  - If time was 01, OVER wins over PAUSE.
- Time never underflows below 00. A tick at 00 is impossible outside OVER and is ignored.
- Latency:
  - Button pulse to state change: 1 cycle.
  - one_hz rising edge to time change: 1 cycle after the edge is sampled.

Decomposition:
- Package game_pkg holds:
  - state encodings STATE_GAME=0, STATE_PAUSE=1, STATE_RESET=2, STATE_OVER=3, and STATE_BITS=2;
  - BCD digit width (4);
  - the 7-segment digit constants shared with the display driver.
- One sub-module, bcd_down_counter (2 digits):
  - inputs: clk, rst, load, load value, dec_en;
  - outputs: tens, ones, is_one, is_zero.
- The FSM and tick edge detector stay in game_ctrl.

Test Plan:
1. Reset and start:
   - Stimulus: rst for 1 cycle, then idle.
   - Required: state=2 for exactly 4 cycles, then 1; time reads 6/0; time_up=0.
   - Then btn_pause: state=0 next cycle, running=1.
2. Countdown:
   - Stimulus: in GAME, apply 3 one_hz rising edges.
   - Required: time 60 -> 59 -> 58 -> 57, one change per edge. one_hz held high for many cycles produces a single decrement.
3. Pause freeze:
   - Stimulus: at 57, btn_pause -> state=1; then 5 one_hz edges.
   - Required: time stays 57.
   - Then btn_pause: state=0 and ticks resume.
4. Game over:
   - Stimulus: GAME_SECONDS=2, start, 2 ticks.
   - Required: 02 -> 01 -> 00 with state=3 on the same edge as 00; time_up=1.
   - Further ticks and btn_pause: no change.
5. Priority:
   - Stimulus: in GAME at 45, btn_reset, btn_pause and tick asserted in the same cycle.
   - Required: state=2, time reloads to 60, no decrement.
   - A second btn_reset on RESET cycle 2 extends RESET to 4 further cycles.
6. Tick+pause collision:
   - Stimulus: at 30, tick and btn_pause in the same cycle.
   - Required: time=29, state=1.
   - At 01, the same collision gives time=00, state=3.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the game sequencer, its BCD countdown and the display driver.
package game_pkg;

  localparam int STATE_BITS = 2;
  localparam int DIGIT_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    STATE_GAME  = 2'd0,
    STATE_PAUSE = 2'd1,
    STATE_RESET = 2'd2,
    STATE_OVER  = 2'd3
  } game_state_e;

  typedef struct packed {
    logic [DIGIT_BITS-1:0] tens;
    logic [DIGIT_BITS-1:0] ones;
  } bcd2_t;

  // Segment patterns ordered gfedcba, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic bcd2_t to_bcd2(input int value);
    bcd2_t r;
    r.tens = 4'(value / 10);
    r.ones = 4'(value % 10);
    return r;
  endfunction

  function automatic logic [6:0] digit_to_seg(input logic [DIGIT_BITS-1:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Button/tick inputs and state/time outputs of the game sequencer.
interface game_ctrl_if;
  import game_pkg::*;

  logic                  btn_pause;
  logic                  btn_reset;
  logic                  one_hz;
  logic [STATE_BITS-1:0] state;
  logic [DIGIT_BITS-1:0] time_tens;
  logic [DIGIT_BITS-1:0] time_ones;
  logic                  time_up;
  logic                  running;

  modport master (
    input  btn_pause, btn_reset, one_hz,
    output state, time_tens, time_ones, time_up, running
  );

  modport slave (
    output btn_pause, btn_reset, one_hz,
    input  state, time_tens, time_ones, time_up, running
  );

endinterface

// File: rtl/game_ctrl_bcd_down_counter.sv
// Two-digit BCD down counter; decrements digit-wise and saturates at 00.
module bcd_down_counter
  import game_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  bcd2_t                 load_val,
  input  logic                  dec_en,
  output logic [DIGIT_BITS-1:0] tens,
  output logic [DIGIT_BITS-1:0] ones,
  output logic                  is_one,
  output logic                  is_zero
);

  logic [DIGIT_BITS-1:0] tens_r, ones_r;
  logic [DIGIT_BITS-1:0] tens_s, ones_s;
  logic                  is_zero_s;

  assign is_zero_s = (tens_r == 4'd0) && (ones_r == 4'd0);

  // Next digit values: load wins, then a borrow-aware decrement.
  always_comb begin
    tens_s = tens_r;
    ones_s = ones_r;
    if (load) begin
      tens_s = load_val.tens;
      ones_s = load_val.ones;
    end else if (dec_en && !is_zero_s) begin
      if (ones_r == 4'd0) begin
        ones_s = 4'd9;
        tens_s = tens_r - 4'd1;
      end else begin
        ones_s = ones_r - 4'd1;
      end
    end else begin
      tens_s = tens_r;
      ones_s = ones_r;
    end
  end

  // Digit registers, reset to the load value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_r <= load_val.tens;
      ones_r <= load_val.ones;
    end else begin
      tens_r <= tens_s;
      ones_r <= ones_s;
    end
  end

  assign tens    = tens_r;
  assign ones    = ones_r;
  assign is_one  = (tens_r == 4'd0) && (ones_r == 4'd1);
  assign is_zero = is_zero_s;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: RESET/PAUSE/GAME/OVER control and one-second BCD countdown.
module game_ctrl
  import game_pkg::*;
#(
  parameter int GAME_SECONDS = 60,
  parameter int RESET_CYCLES = 4,
  parameter int RST_CNT_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  game_ctrl_if.master bus
);

  localparam bcd2_t                   INIT_TIME = to_bcd2(GAME_SECONDS);
  localparam logic [RST_CNT_BITS-1:0] RST_LAST  = RST_CNT_BITS'(RESET_CYCLES - 1);
  localparam logic [RST_CNT_BITS-1:0] RCNT_ONE  = RST_CNT_BITS'(1);
  localparam logic [RST_CNT_BITS-1:0] RCNT_ZERO = RST_CNT_BITS'(0);

  game_state_e             state_r, state_s;
  logic [RST_CNT_BITS-1:0] rcnt_r, rcnt_s;
  logic                    one_hz_q_r;
  logic                    time_up_r, running_r;
  logic                    tick_s, dec_en_s;
  logic                    is_one_s, is_zero_s;

  assign tick_s   = bus.one_hz & ~one_hz_q_r;
  assign dec_en_s = (state_r == STATE_GAME) && tick_s && !bus.btn_reset && !is_zero_s;

  // Next-state logic; btn_reset restarts the hold sequence from anywhere.
  always_comb begin
    state_s = state_r;
    rcnt_s  = RCNT_ZERO;
    if (bus.btn_reset) begin
      state_s = STATE_RESET;
      rcnt_s  = RCNT_ZERO;
    end else begin
      case (state_r)
        STATE_RESET: begin
          if (rcnt_r == RST_LAST) begin
            state_s = STATE_PAUSE;
          end else begin
            rcnt_s = rcnt_r + RCNT_ONE;
          end
        end
        STATE_PAUSE: begin
          if (bus.btn_pause) begin
            state_s = STATE_GAME;
          end else begin
            state_s = STATE_PAUSE;
          end
        end
        STATE_GAME: begin
          // The final tick beats a simultaneous pause request.
          if (tick_s && is_one_s) begin
            state_s = STATE_OVER;
          end else if (bus.btn_pause) begin
            state_s = STATE_PAUSE;
          end else begin
            state_s = STATE_GAME;
          end
        end
        STATE_OVER:  state_s = STATE_OVER;
        default:     state_s = STATE_RESET;
      endcase
    end
  end

  // State, hold counter, tick history and decoded flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= STATE_RESET;
      rcnt_r     <= RCNT_ZERO;
      one_hz_q_r <= 1'b0;
      time_up_r  <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rcnt_r     <= rcnt_s;
      one_hz_q_r <= bus.one_hz;
      time_up_r  <= (state_s == STATE_OVER);
      running_r  <= (state_s == STATE_GAME);
    end
  end

  bcd_down_counter u_time (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.btn_reset),
    .load_val (INIT_TIME),
    .dec_en   (dec_en_s),
    .tens     (bus.time_tens),
    .ones     (bus.time_ones),
    .is_one   (is_one_s),
    .is_zero  (is_zero_s)
  );

  assign bus.state   = state_r;
  assign bus.time_up = time_up_r;
  assign bus.running = running_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed plus random bench for game_ctrl with a seconds-level reference model.
module tb_game_ctrl;

  localparam int MS_GAME  = 0;
  localparam int MS_PAUSE = 1;
  localparam int MS_RESET = 2;
  localparam int MS_OVER  = 3;
  localparam int RC       = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  int   m_state [2];
  int   m_secs  [2];
  int   m_held  [2];
  logic m_prev  [2];
  int   m_init  [2];

  game_ctrl_if if_a ();
  game_ctrl_if if_b ();

  game_ctrl #(.GAME_SECONDS(60), .RESET_CYCLES(4), .RST_CNT_BITS(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  game_ctrl #(.GAME_SECONDS(2), .RESET_CYCLES(4), .RST_CNT_BITS(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Seconds-level model: remaining time is a plain integer, RESET lasts RC whole cycles.
  task automatic model_step(input int k, input logic r, input logic bp, input logic br, input logic hz);
    logic tk;
    tk = hz && !m_prev[k];
    m_prev[k] = r ? 1'b0 : hz;
    if (r || br) begin
      m_state[k] = MS_RESET;
      m_secs[k]  = m_init[k];
      m_held[k]  = 0;
    end else begin
      case (m_state[k])
        MS_RESET: begin
          m_held[k]++;
          if (m_held[k] == RC) m_state[k] = MS_PAUSE;
        end
        MS_PAUSE: if (bp) m_state[k] = MS_GAME;
        MS_GAME: begin
          if (tk && m_secs[k] > 0) m_secs[k]--;
          if (tk && m_secs[k] == 0) m_state[k] = MS_OVER;
          else if (bp) m_state[k] = MS_PAUSE;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cmp_dut(input string nm, input int k, input logic [1:0] st,
                         input logic [3:0] t, input logic [3:0] o, input logic tu, input logic rn);
    check($sformatf("%s.state", nm), {6'd0, st}, 8'(m_state[k]));
    check($sformatf("%s.tens", nm), {4'd0, t}, 8'(m_secs[k] / 10));
    check($sformatf("%s.ones", nm), {4'd0, o}, 8'(m_secs[k] % 10));
    check($sformatf("%s.time_up", nm), {7'd0, tu}, {7'd0, m_state[k] == MS_OVER});
    check($sformatf("%s.running", nm), {7'd0, rn}, {7'd0, m_state[k] == MS_GAME});
  endtask

  task automatic step(input logic r, input logic bp, input logic br, input logic hz);
    @(negedge clk);
    rst = r;
    if_a.btn_pause = bp; if_a.btn_reset = br; if_a.one_hz = hz;
    if_b.btn_pause = bp; if_b.btn_reset = br; if_b.one_hz = hz;
    model_step(0, r, bp, br, hz);
    model_step(1, r, bp, br, hz);
    @(posedge clk);
    #1;
    cmp_dut("a", 0, if_a.state, if_a.time_tens, if_a.time_ones, if_a.time_up, if_a.running);
    cmp_dut("b", 1, if_b.state, if_b.time_tens, if_b.time_ones, if_b.time_up, if_b.running);
  endtask

  task automatic pulse_hz(input int high_cycles);
    for (int i = 0; i < high_cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_time_a(input string tag, input int secs);
    check({tag, ".tens"}, {4'd0, if_a.time_tens}, 8'(secs / 10));
    check({tag, ".ones"}, {4'd0, if_a.time_ones}, 8'(secs % 10));
  endtask

  // Counts consecutive RESET samples on dut_a, already having seen one.
  task automatic count_reset(output int n);
    n = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (if_a.state == 2'd2) n++;
      else break;
    end
  endtask

  initial begin
    int  n;
    logic hz;
    tests = 0;
    fails = 0;
    m_init[0] = 60;
    m_init[1] = 2;
    rst = 1'b1;
    if_a.btn_pause = 1'b0; if_a.btn_reset = 1'b0; if_a.one_hz = 1'b0;
    if_b.btn_pause = 1'b0; if_b.btn_reset = 1'b0; if_b.one_hz = 1'b0;

    // Reset and start.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.state", {6'd0, if_a.state}, 8'd2);
    check_time_a("rst", 60);
    check("rst.time_up", {7'd0, if_a.time_up}, 8'd0);
    count_reset(n);
    check("rst.hold_len", 8'(n), 8'd4);
    check("rst.to_pause", {6'd0, if_a.state}, 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("start.state", {6'd0, if_a.state}, 8'd0);
    check("start.running", {7'd0, if_a.running}, 8'd1);

    // Countdown with long high phases; dut_b runs out on the second edge.
    pulse_hz(6);
    check_time_a("cd1", 59);
    check("b.one.ones", {4'd0, if_b.time_ones}, 8'd1);
    pulse_hz(6);
    check_time_a("cd2", 58);
    check("b.over.state", {6'd0, if_b.state}, 8'd3);
    check("b.over.time_up", {7'd0, if_b.time_up}, 8'd1);
    pulse_hz(6);
    check_time_a("cd3", 57);
    check("b.over.hold", {4'd0, if_b.time_ones}, 8'd0);

    // Pause freeze.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause.state", {6'd0, if_a.state}, 8'd1);
    check("b.pause_ignored", {6'd0, if_b.state}, 8'd3);
    for (int i = 0; i < 5; i++) pulse_hz(2);
    check_time_a("frozen", 57);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("resume.state", {6'd0, if_a.state}, 8'd0);
    pulse_hz(2);
    check_time_a("resumed", 56);

    // Priority of btn_reset over btn_pause and tick.
    for (int i = 0; i < 11; i++) pulse_hz(1);
    check_time_a("at45", 45);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("prio.state", {6'd0, if_a.state}, 8'd2);
    check_time_a("prio", 60);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    count_reset(n);
    check("rst2.hold_len", 8'(n), 8'd4);
    check("rst2.to_pause", {6'd0, if_a.state}, 8'd1);

    // Tick and pause in the same cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) pulse_hz(1);
    check_time_a("at30", 30);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_time_a("coll", 29);
    check("coll.state", {6'd0, if_a.state}, 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) pulse_hz(1);
    check_time_a("at01", 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_time_a("coll_end", 0);
    check("coll_end.state", {6'd0, if_a.state}, 8'd3);
    check("coll_end.time_up", {7'd0, if_a.time_up}, 8'd1);
    pulse_hz(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("over.stuck", {6'd0, if_a.state}, 8'd3);
    check_time_a("over.hold", 0);

    // Random traffic against the model.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    hz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) hz = ~hz;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 149) == 0, hz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
